// File: rtl/mult_div_pkg.sv
// Shared types and constants for the signed multiply/divide unit.
// Build option: MULT_DIV_DIVZERO_TRAP_EN (used by mult_div.sv).
package mult_div_pkg;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;
  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITERATIONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control FSM (master) and mult_div (slave).
interface mult_div_if;

  // mult_start/div_start are single-cycle requests that take effect only while
  // busy is low and done is low (unit idle); a, b are captured on that same
  // edge. done pulses for one cycle when hi/lo carry a fresh result.
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divzero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, done, divzero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, done, divzero
  );

endinterface

// File: rtl/mult_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore the remainder.
module div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] shifted;
  logic        fits;

  always_comb begin
    shifted = {rem_in, quo_in[31]};
    fits    = (shifted >= {1'b0, divisor});
    rem_out = shifted[31:0];
    quo_out = {quo_in[30:0], 1'b0};
    if (fits) begin
      // The difference is below the divisor, so it always fits in 32 bits.
      rem_out = shifted[31:0] - divisor;
      quo_out = {quo_in[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring).
// Build option: MULT_DIV_DIVZERO_TRAP_EN traps division by zero with divzero.
module mult_div
  import mult_div_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mult_div_if.slave bus,
  output state_t    state_dbg
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [32:0]      acc;       // Booth partial product, or division remainder
  logic [31:0]      qreg;      // multiplier being shifted out, or quotient
  logic [31:0]      opb;       // multiplicand, or divisor magnitude
  logic             q_m1;
  logic             neg_q;
  logic             neg_r;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             iter_end;
  logic             dz_trap;
  logic [32:0]      m_ext;
  logic [32:0]      booth_sum;
  logic [31:0]      rem_nxt;
  logic [31:0]      quo_nxt;

  assign iter_end = (cnt == ITER_CNT);

`ifdef MULT_DIV_DIVZERO_TRAP_EN
  logic divzero_q;
  assign dz_trap = (opb == '0);

  always_ff @(posedge clk) begin
    if (reset) divzero_q <= 1'b0;
    else       divzero_q <= (state == DIV) && dz_trap;
  end

  assign bus.divzero = divzero_q;
`else
  assign dz_trap     = 1'b0;
  assign bus.divzero = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mult_start)     state_nxt = MULT;
        else if (bus.div_start) state_nxt = DIV;
      end
      MULT:    if (iter_end) state_nxt = DONE;
      DIV: begin
        if (dz_trap)       state_nxt = IDLE;
        else if (iter_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One extra accumulator bit keeps -2^31 * -2^31 from overflowing mid-run.
  always_comb begin
    m_ext = {opb[31], opb};
    case ({qreg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  div_step u_div_step (
    .rem_in  (acc[31:0]),
    .quo_in  (qreg),
    .divisor (opb),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      qreg  <= '0;
      opb   <= '0;
      q_m1  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt  <= '0;
          acc  <= '0;
          q_m1 <= 1'b0;
          if (state_nxt == MULT) begin
            opb  <= bus.a;
            qreg <= bus.b;
          end else if (state_nxt == DIV) begin
            opb   <= abs32(bus.b);
            qreg  <= abs32(bus.a);
            neg_q <= bus.a[31] ^ bus.b[31];
            neg_r <= bus.a[31];
          end
        end
        MULT: begin
          if (!iter_end) begin
            acc  <= {booth_sum[32], booth_sum[32:1]};
            qreg <= {booth_sum[0], qreg[31:1]};
            q_m1 <= qreg[0];
            cnt  <= cnt + 6'd1;
          end else begin
            hi_q <= acc[31:0];
            lo_q <= qreg;
          end
        end
        DIV: begin
          if (!dz_trap) begin
            if (!iter_end) begin
              acc  <= {1'b0, rem_nxt};
              qreg <= quo_nxt;
              cnt  <= cnt + 6'd1;
            end else begin
              // Quotient truncates toward zero; remainder follows the dividend.
              hi_q <= neg_r ? (~acc[31:0] + 32'd1) : acc[31:0];
              lo_q <= neg_q ? (~qreg + 32'd1) : qreg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state == MULT) || (state == DIV);
  assign bus.done  = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_div.sv
// Directed + random checks of mult_div against a scoreboard of {hi, lo} results.
module tb_mult_div;
  import mult_div_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  mult_div_if bus ();

  mult_div dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (is_mult) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive a start pulse sampled on the next rising edge; a/b are scrambled after.
  task automatic start_op(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b);
    bus.mult_start = ms;
    bus.div_start  = ds;
    bus.a          = a;
    bus.b          = b;
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a          = $urandom;
    bus.b          = $urandom;
  endtask

  task automatic issue(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    exp_q.push_back(exp);
    start_op(ms, ds, a, b);
  endtask

  // Called right after the start edge; poke injects a div_start at that iteration,
  // done_poke injects a mult_start while the unit sits in DONE.
  task automatic wait_result(input string tag, input int poke, input bit done_poke);
    int          lat;
    int          busy_bad;
    int          dz_bad;
    logic [63:0] e;
    busy_bad = 0;
    dz_bad   = 0;
    for (lat = 1; lat <= 40; lat++) begin
      bus.div_start = (poke != 0) && (lat == poke);
      if (bus.div_start) begin
        bus.a = 32'h0000_1234;
        bus.b = 32'h0000_0000;
      end
      @(negedge clk);
      bus.div_start = 1'b0;
      if (bus.divzero !== 1'b0) dz_bad++;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_bad++;
    end
    check({tag, "_latency"}, lat, 33);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_no_divzero"}, dz_bad, 0);
    check({tag, "_busy_done"}, bus.busy, 1'b0);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {bus.hi, bus.lo}, e);
      last_res = e;
    end
    bus.mult_start = done_poke;
    bus.a          = 32'd2;
    bus.b          = 32'd2;
    @(negedge clk);
    bus.mult_start = 1'b0;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"}, state_dbg, IDLE);
    check({tag, "_hold"}, {bus.hi, bus.lo}, last_res);
    @(negedge clk);
    check({tag, "_still_idle"}, state_dbg, IDLE);
  endtask

  initial begin
    int          n_done;
    bit          is_mult;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset, including a start that must lose to reset.
    reset          = 1'b1;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (3) @(negedge clk);
    check("rst_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_divzero", bus.divzero, 1'b0);
    check("rst_state", state_dbg, IDLE);
    bus.mult_start = 1'b1;
    bus.a          = 32'd3;
    bus.b          = 32'd3;
    @(negedge clk);
    check("rst_prio_state", state_dbg, IDLE);
    check("rst_prio_busy", bus.busy, 1'b0);
    bus.mult_start = 1'b0;
    reset          = 1'b0;
    @(negedge clk);

    issue(1, 0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_result("mul_7_m3", 0, 0);
    issue(1, 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_result("mul_min_min", 0, 0);
    issue(0, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_result("div_m7_2", 0, 0);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    wait_result("div_min_m1", 0, 0);
    issue(1, 1, 32'd3, 32'd4, 64'h0000_0000_0000_000C);
    wait_result("both_start", 0, 0);
    issue(1, 0, 32'd1000, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_F448);
    wait_result("mul_div_poke", 5, 0);
    issue(0, 1, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    wait_result("div_done_poke", 0, 1);

`ifdef MULT_DIV_DIVZERO_TRAP_EN
    start_op(0, 1, 32'd5, 32'd0);
    @(negedge clk);
    check("dz_pulse", bus.divzero, 1'b1);
    check("dz_idle", state_dbg, IDLE);
    check("dz_hold", {bus.hi, bus.lo}, last_res);
    @(negedge clk);
    check("dz_one_cycle", bus.divzero, 1'b0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("dz_no_done", n_done, 0);
    check("dz_hold_late", {bus.hi, bus.lo}, last_res);
`else
    issue(0, 1, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
    wait_result("div_5_by_0", 0, 0);
    issue(0, 1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_0000_0001);
    wait_result("div_m5_by_0", 0, 0);
`endif

    // Reset lands on the edge of iteration 10 of a multiply.
    start_op(1, 0, 32'd9, 32'd11);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", state_dbg, IDLE);
    check("abort_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("abort_busy", bus.busy, 1'b0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle_late", state_dbg, IDLE);

    for (int i = 0; i < 8; i++) begin
      is_mult = 1'($urandom_range(0, 1));
      ra      = $urandom;
      rb      = (i % 2 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 3) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      issue(is_mult, !is_mult, ra, rb, model(is_mult, ra, rb));
      wait_result(is_mult ? "rand_mul" : "rand_div", 0, 0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
